fetch_seq: RTL and testbench

- Fetch sequencer for the pipelined MIPS core.
- Owns the F-stage PC register and drives a single-outstanding request/grant/response handshake to instruction memory.
- Presents F_pc and F_instr with a valid flag to the D stage.
- Advances the PC from the next-PC logic's npc output when D consumes the instruction, and redirects on exception or eret, including squashing an in-flight fetch.

---
 rtl/fetch_seq.sv | 120 ++++++++++++
 tb/tb_fetch_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// F-stage fetch sequencer: owns the PC and runs a single-outstanding
// req/gnt/rvalid fetch, presenting one instruction at a time to D.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel
);

  typedef enum logic [1:0] {StReq, StWait, StValid} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        adel_q, adel_d;
  logic        kill_q, kill_d;
  logic        req_raw;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;

  assign redirect    = exc_req | eret;
  assign redirect_pc = exc_req ? EXC_VEC : epc;
  assign misaligned  = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    adel_d  = adel_q;
    kill_d  = kill_q;
    req_raw = 1'b0;
    unique case (state_q)
      StReq: begin
        req_raw = ~misaligned;
        if (redirect) begin
          pc_d = redirect_pc;
          // A grant in the redirect cycle still launches the old fetch; drop its data.
          if (req_raw && imem_gnt) begin
            state_d = StWait;
            kill_d  = 1'b1;
          end
        end else if (misaligned) begin
          state_d = StValid;
          instr_d = 32'h0;
          adel_d  = 1'b1;
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d = imem_rdata;
            adel_d  = 1'b0;
            state_d = StValid;
          end
          if (redirect) pc_d = redirect_pc;
        end else if (redirect) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      StValid: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          adel_d  = 1'b0;
          state_d = StReq;
        end else if (!stall) begin
          pc_d    = npc;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      adel_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      adel_q  <= adel_d;
      kill_q  <= kill_d;
    end
  end

  // Reset state is StReq, so the request must be masked while reset is held.
  assign imem_req  = req_raw & rst_n;
  assign imem_addr = pc_q;
  assign F_pc      = pc_q;
  assign F_instr   = instr_q;
  assign F_valid   = (state_q == StValid);
  assign F_adel    = adel_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a queue scoreboard of expected presentations.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc, epc, imem_addr, imem_rdata, F_pc, F_instr;
  logic        stall, exc_req, eret, imem_req, imem_gnt, imem_rvalid, F_valid, F_adel;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   shown = 1'b0;

  fetch_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc        (npc),
    .stall      (stall),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .F_pc       (F_pc),
    .F_instr    (F_instr),
    .F_valid    (F_valid),
    .F_adel     (F_adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop one expected entry per new presentation on F_valid.
  always @(negedge clk) begin
    if (F_valid && !shown) begin
      shown = 1'b1;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {31'b0, F_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("F_pc", F_pc, e.pc);
        check("F_instr", F_instr, e.instr);
        check("F_adel", {31'b0, F_adel}, {31'b0, e.adel});
      end
    end else if (!F_valid) begin
      shown = 1'b0;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic issue(input logic [31:0] addr, input int gdly);
    for (int i = 0; i < gdly; i++) begin
      #1;
      check("req_hold", {31'b0, imem_req}, 32'h1);
      check("addr_hold", imem_addr, addr);
      @(posedge clk); #1;
    end
    imem_gnt = 1'b1;
    #1;
    check("req_gnt", {31'b0, imem_req}, 32'h1);
    check("addr_gnt", imem_addr, addr);
    @(posedge clk); #1;
    imem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] pc, input logic [31:0] data, input bit keep);
    #1;
    check("wait_noreq", {31'b0, imem_req}, 32'h0);
    if (keep) sb_q.push_back({pc, data, 1'b0});
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
  endtask

  task automatic consume(input logic [31:0] next_pc);
    stall = 1'b0;
    npc   = next_pc;
    #1;
    check("valid_at_consume", {31'b0, F_valid}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; npc = '0; epc = '0; stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_pc", F_pc, 32'h3000);
    check("rst_valid", {31'b0, F_valid}, 32'h0);
    check("rst_instr", F_instr, 32'h0);
    check("rst_adel", {31'b0, F_adel}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic fetch, VALID on the third cycle, then consume.
    issue(32'h3000, 0);
    respond(32'h3000, 32'h2408_0001, 1'b1);
    consume(32'h3004);

    // Stall holds the presentation; release loads npc.
    issue(32'h3004, 0);
    respond(32'h3004, 32'h2409_0002, 1'b1);
    stall = 1'b1;
    repeat (4) begin
      #1;
      check("stall_valid", {31'b0, F_valid}, 32'h1);
      check("stall_pc", F_pc, 32'h3004);
      check("stall_instr", F_instr, 32'h2409_0002);
      check("stall_noreq", {31'b0, imem_req}, 32'h0);
      @(posedge clk); #1;
    end
    consume(32'h3008);

    // Grant delayed three cycles.
    issue(32'h3008, 3);
    respond(32'h3008, 32'h240A_0003, 1'b1);
    consume(32'h3010);

    // Exception while waiting: response dropped, refetch from the vector.
    issue(32'h3010, 0);
    exc_req = 1'b1;
    @(posedge clk); #1;
    exc_req = 1'b0;
    #1;
    check("exc_pc", F_pc, 32'h4180);
    respond(32'h3010, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("kill_novalid", {31'b0, F_valid}, 32'h0);
    issue(32'h4180, 0);
    respond(32'h4180, 32'h240B_0004, 1'b1);

    // eret to a misaligned target overrides stall; no request issued.
    stall = 1'b1;
    eret  = 1'b1;
    epc   = 32'h3022;
    @(posedge clk); #1;
    eret = 1'b0;
    #1;
    check("eret_pc", F_pc, 32'h3022);
    check("adel_noreq", {31'b0, imem_req}, 32'h0);
    sb_q.push_back({32'h3022, 32'h0, 1'b1});
    @(posedge clk); #1;
    check("adel_valid", {31'b0, F_valid}, 32'h1);
    check("adel_noreq2", {31'b0, imem_req}, 32'h0);

    // exc_req wins over eret.
    exc_req = 1'b1;
    eret    = 1'b1;
    @(posedge clk); #1;
    exc_req = 1'b0; eret = 1'b0; stall = 1'b0;
    #1;
    check("prio_pc", F_pc, 32'h4180);
    check("prio_valid", {31'b0, F_valid}, 32'h0);
    check("prio_adel", {31'b0, F_adel}, 32'h0);

    // Async reset during WAIT, then a stale response after release.
    issue(32'h4180, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", F_pc, 32'h3000);
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_valid", {31'b0, F_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    issue(32'h3000, 0);
    respond(32'h3000, 32'h2408_0001, 1'b1);
    consume(32'h3004);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
